// File: rtl/bat_amateur_pkg.sv
// ---------------------------------------------------------------------------
// bat_amateur_pkg
//   Shared definitions for the RAM dump engine:
//     DEF_ADDRESS_WIDTH / DEF_DATA_WIDTH  default bus widths
//     COUNT_WIDTH                         width of the word-count request
//     DUMP_CSUM_ADDR                      address tag carried by the checksum beat
//     dump_state_t                        dump FSM state encoding
//   Optional feature macro: BAT_DUMP_CHECKSUM_EN. ST_CSUM is declared
//   unconditionally so the encoding is identical in both builds. It is
//   simply never entered when the macro is undefined.
// ---------------------------------------------------------------------------
package bat_amateur_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned COUNT_WIDTH       = 16;

    localparam logic [15:0] DUMP_CSUM_ADDR    = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GRAB = 3'd1,
        ST_READ = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4,
        ST_CSUM = 3'd5,
        ST_FIN  = 3'd6
    } dump_state_t;

endpackage

// File: rtl/bat_amateur_rd_delay.sv
// ---------------------------------------------------------------------------
// bat_amateur_rd_delay
//   Delays the one-cycle RAM read strobe by DEPTH cycles. The delayed pulse
//   marks the cycle in which DATA_BUS holds the word that was addressed
//   DEPTH cycles earlier.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset (clears the pipeline)
//   strobe_in   in   read strobe (high for the single READ cycle)
//   strobe_out  out  strobe_in delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module bat_amateur_rd_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic strobe_out
);

    logic [DEPTH-1:0] tap_q;
    logic [DEPTH-1:0] tap_d;

    assign tap_d[0] = strobe_in;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tap
            assign tap_d[gi] = tap_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign strobe_out = tap_q[DEPTH-1];

endmodule

// File: rtl/bat_amateur_ram_dump.sv
// ---------------------------------------------------------------------------
// bat_amateur_ram_dump
//   Read-back engine. On START it halts the CPU, takes the RAM bus, reads
//   WORD_COUNT words from START_ADDR and streams (address, data) pairs out
//   over a valid/ready port, then releases the bus and drops HALT.
//   Optional feature macro: BAT_DUMP_CHECKSUM_EN. When defined, a wrapping
//   sum of all words read is sent as an extra final beat tagged with
//   DUMP_CSUM_ADDR, and that beat carries DUMP_LAST instead of the last data
//   word.
// Ports:
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-low reset
//   START        in   one-cycle request, sampled only while idle
//   START_ADDR   in   first address, captured with START
//   WORD_COUNT   in   number of words to read, captured with START (0 = none)
//   HALT         out  holds the CPU off the bus while the dump runs
//   RAM_EN       out  RAM enable, high only in the read strobe cycle
//   RAM_RW       out  constant 1 (read); this block never writes
//   ADDRESS_BUS  out  RAM address, high-Z when the bus is not owned
//   DATA_BUS     in   RAM read data
//   DUMP_ADDR    out  address of the presented word
//   DUMP_DATA    out  presented word
//   DUMP_VALID   out  DUMP_ADDR/DUMP_DATA/DUMP_LAST are valid
//   DUMP_READY   in   consumer accepts on VALID & READY at a CLK edge
//   DUMP_LAST    out  marks the final beat
//   BUSY         out  high from the cycle after START until DONE
//   DONE         out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module bat_amateur_ram_dump
    import bat_amateur_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned RAM_READ_LATENCY = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [ADDRESS_WIDTH-1:0] START_ADDR,
    input  logic [COUNT_WIDTH-1:0]   WORD_COUNT,
    output logic                     HALT,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output wire  [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
    input  logic [DATA_WIDTH-1:0]    DATA_BUS,
    output logic [ADDRESS_WIDTH-1:0] DUMP_ADDR,
    output logic [DATA_WIDTH-1:0]    DUMP_DATA,
    output logic                     DUMP_VALID,
    input  logic                     DUMP_READY,
    output logic                     DUMP_LAST,
    output logic                     BUSY,
    output logic                     DONE
);

    // Supported RAM latencies are 1..4; out-of-range values are clamped so
    // the delay line never collapses to zero depth.
    localparam int unsigned LAT = (RAM_READ_LATENCY < 1) ? 1 :
                                  (RAM_READ_LATENCY > 4) ? 4 : RAM_READ_LATENCY;

    dump_state_t              state_q,  state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,   addr_d;
    logic [COUNT_WIDTH-1:0]   remain_q, remain_d;
    logic [DATA_WIDTH-1:0]    data_q,   data_d;
`ifdef BAT_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    sum_q,    sum_d;
`endif

    logic read_strobe;
    logic capture;
    logic bus_drive;
    logic beat_accept;

    // -----------------------------------------------------------------------
    // Read-data timing: the strobe issued in READ comes back LAT cycles later,
    // which is the last WAIT cycle, when DATA_BUS carries the addressed word.
    // -----------------------------------------------------------------------
    assign read_strobe = (state_q == ST_READ);

    bat_amateur_rd_delay #(
        .DEPTH      (LAT)
    ) u_rd_delay (
        .clk        (CLK),
        .rst_n      (RESET),
        .strobe_in  (read_strobe),
        .strobe_out (capture)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
`ifdef BAT_DUMP_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
`ifdef BAT_DUMP_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        data_d      = data_q;
`ifdef BAT_DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        HALT        = 1'b0;
        RAM_EN      = 1'b0;
        RAM_RW      = 1'b1;
        bus_drive   = 1'b0;
        DUMP_VALID  = 1'b0;
        DUMP_ADDR   = '0;
        DUMP_DATA   = '0;
        DUMP_LAST   = 1'b0;
        BUSY        = 1'b0;
        DONE        = 1'b0;
        beat_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    addr_d   = START_ADDR;
                    remain_d = WORD_COUNT;
`ifdef BAT_DUMP_CHECKSUM_EN
                    sum_d    = '0;
`endif
                    // An empty request completes without touching the bus.
                    state_d  = (WORD_COUNT != '0) ? ST_GRAB : ST_FIN;
                end
            end

            ST_GRAB: begin
                // CPU is held off for one cycle before the bus is driven.
                HALT    = 1'b1;
                BUSY    = 1'b1;
                state_d = ST_READ;
            end

            ST_READ: begin
                HALT      = 1'b1;
                BUSY      = 1'b1;
                RAM_EN    = 1'b1;
                bus_drive = 1'b1;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                HALT      = 1'b1;
                BUSY      = 1'b1;
                bus_drive = 1'b1;
                if (capture) begin
                    data_d  = DATA_BUS;
`ifdef BAT_DUMP_CHECKSUM_EN
                    sum_d   = sum_q + DATA_BUS;
`endif
                    state_d = ST_OUT;
                end
            end

            ST_OUT: begin
                HALT        = 1'b1;
                BUSY        = 1'b1;
                bus_drive   = 1'b1;
                DUMP_VALID  = 1'b1;
                DUMP_ADDR   = addr_q;
                DUMP_DATA   = data_q;
`ifdef BAT_DUMP_CHECKSUM_EN
                DUMP_LAST   = 1'b0;
`else
                DUMP_LAST   = (remain_q == COUNT_WIDTH'(1));
`endif
                beat_accept = DUMP_READY;
                if (beat_accept) begin
                    addr_d   = addr_q + ADDRESS_WIDTH'(1);
                    remain_d = remain_q - COUNT_WIDTH'(1);
                    if (remain_q != COUNT_WIDTH'(1)) begin
                        state_d = ST_READ;
                    end else begin
`ifdef BAT_DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_FIN;
`endif
                    end
                end
            end

`ifdef BAT_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                // Bus and CPU are already released while the sum is offered.
                BUSY        = 1'b1;
                DUMP_VALID  = 1'b1;
                DUMP_ADDR   = ADDRESS_WIDTH'(DUMP_CSUM_ADDR);
                DUMP_DATA   = sum_q;
                DUMP_LAST   = 1'b1;
                beat_accept = DUMP_READY;
                if (beat_accept) begin
                    state_d = ST_FIN;
                end
            end
`endif

            ST_FIN: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ADDRESS_BUS = bus_drive ? addr_q : {ADDRESS_WIDTH{1'bz}};

endmodule

// File: tb/tb_bat_amateur_ram_dump.sv
// ---------------------------------------------------------------------------
// tb_bat_amateur_ram_dump
//   Self-checking bench for bat_amateur_ram_dump: a table of directed dumps
//   followed by randomized dumps, each compared beat-by-beat against a
//   reference computed directly from the RAM image.
// ---------------------------------------------------------------------------
module tb_bat_amateur_ram_dump;

    localparam int LAT = 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] sa;
        logic [15:0] cnt;
        int          stall_beat;
        int          stall_len;
        int          rst_cyc;
        int          exp_beats;
        logic [15:0] exp_last_addr;
        logic [15:0] exp_last_data;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [15:0] START_ADDR = 16'h0;
    logic [15:0] WORD_COUNT = 16'h0;
    logic        HALT;
    logic        RAM_EN;
    logic        RAM_RW;
    wire  [15:0] ADDRESS_BUS;
    logic [15:0] DATA_BUS;
    logic [15:0] DUMP_ADDR;
    logic [15:0] DUMP_DATA;
    logic        DUMP_VALID;
    logic        DUMP_READY = 1'b1;
    logic        DUMP_LAST;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram [0:65535];
    logic [15:0] rd_pipe [0:LAT-1];

    beat_t exp_q[$];
    beat_t got_q[$];

    always #5 CLK = ~CLK;

    bat_amateur_ram_dump #(
        .ADDRESS_WIDTH    (16),
        .DATA_WIDTH       (16),
        .RAM_READ_LATENCY (LAT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .START_ADDR  (START_ADDR),
        .WORD_COUNT  (WORD_COUNT),
        .HALT        (HALT),
        .RAM_EN      (RAM_EN),
        .RAM_RW      (RAM_RW),
        .ADDRESS_BUS (ADDRESS_BUS),
        .DATA_BUS    (DATA_BUS),
        .DUMP_ADDR   (DUMP_ADDR),
        .DUMP_DATA   (DUMP_DATA),
        .DUMP_VALID  (DUMP_VALID),
        .DUMP_READY  (DUMP_READY),
        .DUMP_LAST   (DUMP_LAST),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    // RAM model: data is valid exactly LAT cycles after the enabled cycle,
    // and a junk pattern otherwise so a mistimed capture is visible.
    always @(posedge CLK) begin
        rd_pipe[0] <= RAM_EN ? ram[ADDRESS_BUS] : 16'hDEAD;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign DATA_BUS = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the dump is the words sa, sa+1, ... (mod 2^16) in order,
    // last one flagged; with the checksum option a sum beat follows.
    function automatic void build_expected(input logic [15:0] sa, input logic [15:0] cnt);
        logic [15:0] sum;
        logic [15:0] a;
        beat_t b;
        exp_q.delete();
        sum = 16'h0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = sa + 16'(i);
            b.addr = a;
            b.data = ram[a];
            b.last = (i == int'(cnt) - 1);
            sum = sum + ram[a];
            exp_q.push_back(b);
        end
`ifdef BAT_DUMP_CHECKSUM_EN
        if (cnt != 16'h0) begin
            exp_q[exp_q.size()-1].last = 1'b0;
            b.addr = 16'hFFFF;
            b.data = sum;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
`endif
    endfunction

    function automatic logic [38:0] reset_vector();
        return {HALT, RAM_EN, RAM_RW, DUMP_VALID, DUMP_LAST, BUSY, DONE, DUMP_ADDR, DUMP_DATA};
    endfunction

    task automatic run_dump(input logic [15:0] sa, input logic [15:0] cnt,
                            input int stall_beat, input int stall_len,
                            input int rst_cyc, input string tag);
        logic [15:0] en_addr_q[$];
        int acc_cyc[$];
        int cyc, first_valid, done_cyc, stall_cnt, unstable, misc_bad, halt_cnt, busy_cnt;
        bit done_seen, prev_hold, did_rst;
        beat_t prev_beat, cur;
        logic exp_halt_on_last;

`ifdef BAT_DUMP_CHECKSUM_EN
        exp_halt_on_last = 1'b0;
`else
        exp_halt_on_last = 1'b1;
`endif
        build_expected(sa, cnt);
        got_q.delete();
        first_valid = -1; done_cyc = -1; stall_cnt = 0; unstable = 0; misc_bad = 0;
        halt_cnt = 0; busy_cnt = 0; done_seen = 0; prev_hold = 0; did_rst = 0;
        prev_beat = '0;

        @(negedge CLK);
        START = 1'b1; START_ADDR = sa; WORD_COUNT = cnt; DUMP_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0; START_ADDR = 16'($urandom); WORD_COUNT = 16'($urandom);
        cyc = 1;
        while (cyc < 2000 && !done_seen) begin
            if (RAM_RW !== 1'b1) misc_bad++;
            if (RAM_EN === 1'b1) en_addr_q.push_back(ADDRESS_BUS);
            if (HALT === 1'b1) halt_cnt++;
            if (BUSY === 1'b1) busy_cnt++;
            if (DONE === 1'b1) begin
                done_seen = 1;
                done_cyc = cyc;
                if (HALT || BUSY || DUMP_VALID) misc_bad++;
            end
            if (prev_hold) begin
                cur = '{DUMP_ADDR, DUMP_DATA, DUMP_LAST};
                if (DUMP_VALID !== 1'b1 || cur !== prev_beat) unstable++;
            end
            if (DUMP_VALID === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (DUMP_LAST === 1'b1 && HALT !== exp_halt_on_last) misc_bad++;
                if (DUMP_LAST === 1'b0 && HALT !== 1'b1) misc_bad++;
            end
            if (cyc == rst_cyc) begin
                check({tag, "_pre_rst_wait"}, {61'h0, HALT, RAM_EN, DUMP_VALID}, 64'b100);
                START = 1'b0;
                RESET = 1'b0;
                #1;
                check({tag, "_rst_now"}, {25'h0, reset_vector()}, {25'h0, 7'b0010000, 32'h0});
                @(negedge CLK);
                RESET = 1'b1;
                did_rst = 1;
                break;
            end
            if (DUMP_VALID === 1'b1 && got_q.size() == stall_beat && stall_cnt < stall_len) begin
                DUMP_READY = 1'b0;
                stall_cnt++;
            end else begin
                DUMP_READY = 1'b1;
            end
            if (DUMP_VALID === 1'b1) begin
                cur = '{DUMP_ADDR, DUMP_DATA, DUMP_LAST};
                if (DUMP_READY) begin
                    got_q.push_back(cur);
                    acc_cyc.push_back(cyc);
                end
                prev_hold = !DUMP_READY;
                prev_beat = cur;
            end else begin
                prev_hold = 0;
            end
            // Requests while busy must be ignored.
            START = (BUSY === 1'b1) && ($urandom_range(0, 3) == 0);
            START_ADDR = 16'($urandom);
            WORD_COUNT = 16'($urandom_range(1, 5));
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        DUMP_READY = 1'b1;

        if (did_rst) begin
            $display("run %s: sa=%h cnt=%0d reset at cycle %0d beats=%0d", tag, sa, cnt, rst_cyc, got_q.size());
            return;
        end

        check({tag, "_done"}, 64'(done_seen), 64'd1);
        check({tag, "_after_done"}, {61'h0, DONE, HALT, BUSY}, 64'h0);
        check({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_ram_en_count"}, 64'(en_addr_q.size()), 64'(cnt));
        for (int i = 0; i < en_addr_q.size(); i++) begin
            if (en_addr_q[i] !== sa + 16'(i)) misc_bad++;
        end
        if (stall_len == 0) begin
            for (int i = 1; i < acc_cyc.size() && i < int'(cnt); i++) begin
                if (acc_cyc[i] - acc_cyc[i-1] != 2 + LAT) misc_bad++;
            end
        end
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        check({tag, "_protocol"}, 64'(misc_bad), 64'd0);
        if (cnt == 16'h0) begin
            check({tag, "_zero_done_cyc"}, 64'(done_cyc), 64'd1);
            check({tag, "_zero_halt_busy"}, 64'(halt_cnt + busy_cnt), 64'd0);
        end else begin
            check({tag, "_first_latency"}, 64'(first_valid), 64'(3 + LAT));
        end
        $display("run %s: sa=%h cnt=%0d stall=%0d/%0d beats=%0d done_cyc=%0d",
                 tag, sa, cnt, stall_beat, stall_len, got_q.size(), done_cyc);
    endtask

    vec_t vecs[6];

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[16'h0010] = 16'h0005;
        ram[16'h0011] = 16'h0000;
        ram[16'h0012] = 16'h0001;
        ram[16'hFFFF] = 16'hABCD;
        ram[16'h0000] = 16'h1234;

`ifdef BAT_DUMP_CHECKSUM_EN
        vecs[0] = '{16'h0010, 16'd3, -1, 0, -1, 4, 16'hFFFF, 16'h0006};
        vecs[1] = '{16'h0010, 16'd3,  1, 5, -1, 4, 16'hFFFF, 16'h0006};
        vecs[2] = '{16'hFFFF, 16'd2, -1, 0, -1, 3, 16'hFFFF, 16'hBE01};
`else
        vecs[0] = '{16'h0010, 16'd3, -1, 0, -1, 3, 16'h0012, 16'h0001};
        vecs[1] = '{16'h0010, 16'd3,  1, 5, -1, 3, 16'h0012, 16'h0001};
        vecs[2] = '{16'hFFFF, 16'd2, -1, 0, -1, 2, 16'h0000, 16'h1234};
`endif
        vecs[3] = '{16'h0040, 16'd0, -1, 0, -1, 0, 16'h0000, 16'h0000};
        vecs[4] = '{16'h0010, 16'd3, -1, 0, 5 + LAT, -1, 16'h0000, 16'h0000};
        vecs[5] = vecs[0];

        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", {25'h0, reset_vector()}, {25'h0, 7'b0010000, 32'h0});
        RESET = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            run_dump(vecs[v].sa, vecs[v].cnt, vecs[v].stall_beat, vecs[v].stall_len,
                     vecs[v].rst_cyc, $sformatf("vec%0d", v));
            if (vecs[v].exp_beats >= 0) begin
                check($sformatf("vec%0d_tbl_nbeats", v), 64'(got_q.size()), 64'(vecs[v].exp_beats));
                if (vecs[v].exp_beats > 0 && got_q.size() > 0) begin
                    check($sformatf("vec%0d_tbl_last", v), 64'(got_q[got_q.size()-1]),
                          64'(beat_t'({vecs[v].exp_last_addr, vecs[v].exp_last_data, 1'b1})));
                end
            end
        end

        for (int r = 0; r < 30; r++) begin
            logic [15:0] sa;
            logic [15:0] cnt;
            int sb;
            cnt = 16'($urandom_range(0, 6));
            sa = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            sb = $urandom_range(0, 6);
            run_dump(sa, cnt, sb, $urandom_range(0, 4), -1, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
